// File: rtl/instr_fetcher_pkg.sv
// Shared constants and types for the instruction fetcher and its queue.
package instr_fetcher_pkg;
  localparam int ADDR_W_DEF   = 32;
  localparam int IQ_DEPTH_DEF = 16;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {FETCH = 1'b0, PRED = 1'b1} fetch_state_t;
endpackage

// File: rtl/instr_queue.sv
// Synchronous FIFO of packed {instr, pc, pred} entries with flush.
// Head is presented combinationally from storage.
module instr_queue
  import instr_fetcher_pkg::*;
#(
  parameter int W     = 65,
  parameter int DEPTH = IQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
endmodule

// File: rtl/instr_fetcher.sv
// Front-end fetcher: requests words from the icache, resolves next PC (JAL
// directly, conditional branches via a one-shot predictor query) and queues them.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PRED_IDX_W = 8,
  parameter int IQ_DEPTH   = IQ_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic                  icache_req,
  output logic [ADDR_W-1:0]     icache_addr,
  input  logic                  icache_valid,
  input  logic [31:0]           icache_instr,
  output logic                  pred_req,
  output logic [PRED_IDX_W-1:0] pred_index,
  input  logic                  pred_jump,
  output logic                  out_valid,
  output logic [31:0]           out_instr,
  output logic [ADDR_W-1:0]     out_pc,
  output logic                  out_pred_jump,
  input  logic                  dec_ready,
  input  logic                  rob_flush,
  input  logic [ADDR_W-1:0]     rob_target_pc
);
  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;
  localparam int ENT_W = 32 + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       br_instr_q, br_instr_d;
  logic              icache_req_q, icache_req_d;
  logic              pred_req_q, pred_req_d;

  logic              iq_push, iq_pop, iq_flush, push_pred;
  logic [31:0]       push_instr;
  logic [ENT_W-1:0]  iq_head;
  logic [CNT_W-1:0]  iq_count, cnt_nx;

  function automatic logic signed [ADDR_W-1:0] b_imm(input logic [31:0] i);
    return {{(ADDR_W-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [ADDR_W-1:0] j_imm(input logic [31:0] i);
    return {{(ADDR_W-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    br_instr_d   = br_instr_q;
    icache_req_d = icache_req_q;
    pred_req_d   = pred_req_q;
    iq_push      = FALSE;
    iq_pop       = FALSE;
    iq_flush     = FALSE;
    push_instr   = icache_instr;
    push_pred    = FALSE;
    cnt_nx       = iq_count;
    if (rdy) begin
      if (rob_flush) begin
        iq_flush     = TRUE;
        pc_d         = rob_target_pc;
        state_d      = FETCH;
        pred_req_d   = FALSE;
        icache_req_d = TRUE;
      end else begin
        iq_pop = out_valid && dec_ready;
        if (state_q == FETCH) begin
          if (icache_req_q && icache_valid) begin
            case (icache_instr[6:0])
              OP_BRANCH: begin
                br_instr_d = icache_instr;
                state_d    = PRED;
                pred_req_d = TRUE;
              end
              OP_JAL: begin
                iq_push   = TRUE;
                push_pred = TRUE;
                pc_d      = pc_q + $unsigned(j_imm(icache_instr));
              end
              OP_JALR: begin
                iq_push = TRUE;
                pc_d    = pc_q + PC_STEP;
              end
              default: begin
                iq_push = TRUE;
                pc_d    = pc_q + PC_STEP;
              end
            endcase
          end
        end else if (pred_req_q) begin
          pred_req_d = FALSE;
        end else begin
          // Prediction arrives the cycle after the query; branch pc is still in pc_q.
          iq_push    = TRUE;
          push_instr = br_instr_q;
          push_pred  = pred_jump;
          pc_d       = pred_jump ? pc_q + $unsigned(b_imm(br_instr_q)) : pc_q + PC_STEP;
          state_d    = FETCH;
        end
        if (iq_push && !iq_pop)      cnt_nx = iq_count + CNT_W'(1);
        else if (!iq_push && iq_pop) cnt_nx = iq_count - CNT_W'(1);
        icache_req_d = (state_d == FETCH) && (cnt_nx != CNT_W'(IQ_DEPTH));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      icache_req_q <= FALSE;
      pred_req_q   <= FALSE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      icache_req_q <= icache_req_d;
      pred_req_q   <= pred_req_d;
    end
  end

  always_ff @(posedge clk) begin
    br_instr_q <= br_instr_d;
  end

  instr_queue #(.W(ENT_W), .DEPTH(IQ_DEPTH)) u_iq (
    .clk       (clk),
    .rst       (rst),
    .push      (iq_push),
    .push_data ({push_instr, pc_q, push_pred}),
    .pop       (iq_pop),
    .flush     (iq_flush),
    .head_data (iq_head),
    .count     (iq_count)
  );

  assign icache_req  = icache_req_q;
  assign icache_addr = pc_q;
  assign pred_req    = pred_req_q;
  assign pred_index  = pc_q[PRED_IDX_W+1:2];
  assign out_valid   = (iq_count != '0);
  assign {out_instr, out_pc, out_pred_jump} = iq_head;
endmodule

// File: tb/tb_instr_fetcher.sv
// Directed and randomized checks of instr_fetcher against a transaction-level model.
module tb_instr_fetcher;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        icache_req, icache_valid;
  logic [31:0] icache_addr, icache_instr;
  logic        pred_req, pred_jump;
  logic [7:0]  pred_index;
  logic        out_valid, out_pred_jump, dec_ready, rob_flush;
  logic [31:0] out_instr, out_pc, rob_target_pc;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, br_instr, rnd, instr;
  int          stage, br_off, off, kind, dec_pct, f1, f2, f3, f4;
  logic        exp_req;

  localparam logic [31:0] BEQ_M4 = 32'hFE000EE3;

  always #5 clk = ~clk;

  instr_fetcher #(.ADDR_W(32), .PRED_IDX_W(8), .IQ_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_instr(icache_instr),
    .pred_req(pred_req), .pred_index(pred_index), .pred_jump(pred_jump),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pred_jump(out_pred_jump), .dec_ready(dec_ready),
    .rob_flush(rob_flush), .rob_target_pc(rob_target_pc)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] tgt);
    rob_flush = 1'b1;
    rob_target_pc = tgt;
    tick();
    rob_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; icache_valid = 1'b0; icache_instr = '0;
    pred_jump = 1'b0; dec_ready = 1'b0; rob_flush = 1'b0; rob_target_pc = '0;
    tick(); tick();
    chk1("rst_icache_req", icache_req, 1'b0);
    chk1("rst_pred_req", pred_req, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_addr", icache_addr, 32'h0);
    rst = 1'b1;
    tick();
    chk1("first_req", icache_req, 1'b1);
    chkw("first_addr", icache_addr, 32'h0);

    // plain ALU word at pc 0
    icache_valid = 1'b1; icache_instr = 32'h00000013;
    tick();
    icache_valid = 1'b0;
    chk1("nop_valid", out_valid, 1'b1);
    chkw("nop_instr", out_instr, 32'h00000013);
    chkw("nop_pc", out_pc, 32'h0);
    chk1("nop_pred", out_pred_jump, 1'b0);
    chkw("nop_next_addr", icache_addr, 32'h4);
    chk1("nop_req", icache_req, 1'b1);

    // JAL +8 at 0x10
    flush_to(32'h10);
    chk1("fl10_empty", out_valid, 1'b0);
    chkw("fl10_addr", icache_addr, 32'h10);
    icache_valid = 1'b1; icache_instr = 32'h0080006F;
    tick();
    icache_valid = 1'b0;
    chkw("jal_pc", out_pc, 32'h10);
    chk1("jal_pred", out_pred_jump, 1'b1);
    chkw("jal_next_addr", icache_addr, 32'h18);
    chk1("jal_no_pred_req", pred_req, 1'b0);

    // branch at 0x20, taken then not taken
    for (int t = 1; t >= 0; t--) begin
      flush_to(32'h20);
      icache_valid = 1'b1; icache_instr = BEQ_M4;
      tick();
      icache_valid = 1'b0;
      chk1("br_pred_req", pred_req, 1'b1);
      chkw("br_index", 32'(pred_index), 32'h08);
      chk1("br_req_low", icache_req, 1'b0);
      chk1("br_no_push", out_valid, 1'b0);
      tick();
      chk1("br_pred_req_once", pred_req, 1'b0);
      pred_jump = t[0];
      tick();
      pred_jump = 1'b0;
      chkw("br_next_addr", icache_addr, (t == 1) ? 32'h1C : 32'h24);
      chk1("br_req_back", icache_req, 1'b1);
      chk1("br_pushed", out_valid, 1'b1);
      chkw("br_pc", out_pc, 32'h20);
      chkw("br_instr", out_instr, BEQ_M4);
      chk1("br_pred", out_pred_jump, t[0]);
    end

    // rdy low for 3 cycles while the prediction query is outstanding
    flush_to(32'h20);
    icache_valid = 1'b1; icache_instr = BEQ_M4;
    tick();
    rdy = 1'b0; rob_flush = 1'b1; rob_target_pc = 32'h300;
    icache_instr = 32'h00000013; pred_jump = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("frz_pred_req", pred_req, 1'b1);
      chkw("frz_index", 32'(pred_index), 32'h08);
      chk1("frz_req", icache_req, 1'b0);
      chk1("frz_out_valid", out_valid, 1'b0);
    end
    rdy = 1'b1; rob_flush = 1'b0; icache_valid = 1'b0; pred_jump = 1'b0;
    tick();
    chk1("frz_resume_pred_req", pred_req, 1'b0);
    pred_jump = 1'b1;
    tick();
    pred_jump = 1'b0;
    chkw("frz_resume_addr", icache_addr, 32'h1C);
    chkw("frz_resume_pc", out_pc, 32'h20);
    chk1("frz_resume_pred", out_pred_jump, 1'b1);

    // flush lands on the prediction-sample cycle
    flush_to(32'h20);
    icache_valid = 1'b1; icache_instr = 32'h00000013;
    tick();
    icache_instr = BEQ_M4;
    tick();
    icache_valid = 1'b0;
    chk1("flp_pred_req", pred_req, 1'b1);
    chkw("flp_index", 32'(pred_index), 32'h09);
    chk1("flp_nonempty", out_valid, 1'b1);
    tick();
    rob_flush = 1'b1; rob_target_pc = 32'h100; pred_jump = 1'b1;
    icache_valid = 1'b1; icache_instr = 32'h00000013;
    tick();
    rob_flush = 1'b0; pred_jump = 1'b0; icache_valid = 1'b0;
    chk1("flp_empty", out_valid, 1'b0);
    chkw("flp_addr", icache_addr, 32'h100);
    chk1("flp_req", icache_req, 1'b1);
    chk1("flp_pred_req_low", pred_req, 1'b0);
    tick();
    chk1("flp_still_empty", out_valid, 1'b0);

    // fill to 16, stall, free one slot, wrap
    flush_to(32'h0);
    icache_valid = 1'b1; icache_instr = 32'h00000013;
    for (int i = 0; i < 16; i++) begin
      chk1("fill_req", icache_req, 1'b1);
      chkw("fill_addr", icache_addr, 32'(4 * i));
      tick();
    end
    chk1("full_req_low", icache_req, 1'b0);
    chkw("full_addr", icache_addr, 32'h40);
    tick();
    chk1("full_hold_req", icache_req, 1'b0);
    chkw("full_hold_addr", icache_addr, 32'h40);
    chkw("full_head", out_pc, 32'h0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk1("pop_req_resume", icache_req, 1'b1);
    chkw("pop_head", out_pc, 32'h4);
    tick();
    icache_valid = 1'b0;
    chk1("refull_req_low", icache_req, 1'b0);
    chkw("refull_addr", icache_addr, 32'h44);
    for (int i = 0; i < 16; i++) begin
      chk1("drain_valid", out_valid, 1'b1);
      chkw("drain_pc", out_pc, 32'(4 * (i + 1)));
      dec_ready = 1'b1;
      tick();
    end
    dec_ready = 1'b0;
    chk1("drain_empty", out_valid, 1'b0);
    chk1("drain_req", icache_req, 1'b1);

    // randomized traffic against the transaction model
    flush_to(32'h1000);
    m_pc = 32'h1000; stage = 0; mq.delete(); br_instr = '0; br_off = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_req = (stage == 0) && (mq.size() < 16);
      chk1("rnd_icache_req", icache_req, exp_req);
      chk1("rnd_pred_req", pred_req, stage == 1);
      chk1("rnd_out_valid", out_valid, mq.size() != 0);
      if (exp_req) chkw("rnd_icache_addr", icache_addr, m_pc);
      if (stage == 1) chkw("rnd_pred_index", 32'(pred_index), {24'd0, m_pc[9:2]});

      dec_pct = ((cyc / 250) % 3 == 0) ? 5 : (((cyc / 250) % 3 == 1) ? 95 : 50);
      rdy       = ($urandom_range(0, 7) != 0);
      rob_flush = ($urandom_range(0, 59) == 0);
      rob_target_pc = $urandom & 32'hFFFF_FFFC;
      dec_ready = (int'($urandom_range(0, 99)) < dec_pct);
      icache_valid = ($urandom_range(0, 9) < 6);
      pred_jump = $urandom_range(0, 1) == 1;
      rnd  = $urandom;
      kind = int'($urandom_range(0, 3));
      f1 = int'($urandom_range(0, 1));
      f2 = int'($urandom_range(0, 1));
      case (kind)
        0: begin
          f3 = int'($urandom_range(0, 63));
          f4 = int'($urandom_range(0, 15));
          instr = {f1[0], f3[5:0], rnd[24:12], f4[3:0], f2[0], 7'b1100011};
          off = f2 * 2048 + f3 * 32 + f4 * 2 - f1 * 4096;
        end
        1: begin
          f3 = int'($urandom_range(0, 255));
          f4 = int'($urandom_range(0, 1023));
          instr = {f1[0], f4[9:0], f2[0], f3[7:0], rnd[11:7], 7'b1101111};
          off = f3 * 4096 + f2 * 2048 + f4 * 2 - f1 * 1048576;
        end
        2: begin
          instr = {rnd[31:7], 7'b1100111};
          off = 4;
        end
        default: begin
          instr = rnd;
          if (rnd[6:0] == 7'b1100011 || rnd[6:0] == 7'b1101111) instr[6:0] = 7'b0110011;
          off = 4;
        end
      endcase
      icache_instr = instr;

      if (rdy) begin
        if (rob_flush) begin
          mq.delete();
          m_pc = rob_target_pc;
          stage = 0;
        end else begin
          if (mq.size() != 0 && dec_ready) begin
            chkw("rnd_head_instr", out_instr, mq[0].instr);
            chkw("rnd_head_pc", out_pc, mq[0].pc);
            chk1("rnd_head_pred", out_pred_jump, mq[0].pred);
            void'(mq.pop_front());
          end
          if (stage == 0) begin
            if (exp_req && icache_valid) begin
              if (kind == 0) begin
                br_instr = instr; br_off = off; stage = 1;
              end else begin
                mq.push_back('{instr: instr, pc: m_pc, pred: (kind == 1)});
                m_pc = m_pc + off;
              end
            end
          end else if (stage == 1) begin
            stage = 2;
          end else begin
            mq.push_back('{instr: br_instr, pc: m_pc, pred: pred_jump});
            m_pc = m_pc + (pred_jump ? br_off : 4);
            stage = 0;
          end
        end
      end
      tick();
    end

    // asynchronous reset while a branch prediction is in flight
    rdy = 1'b1; rob_flush = 1'b0; dec_ready = 1'b0; pred_jump = 1'b0;
    flush_to(32'h20);
    icache_valid = 1'b1; icache_instr = 32'h00000013;
    tick();
    icache_instr = BEQ_M4;
    tick();
    icache_valid = 1'b0;
    chk1("arst_pre_pred_req", pred_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk1("arst_pred_req", pred_req, 1'b0);
    chk1("arst_icache_req", icache_req, 1'b0);
    chkw("arst_addr", icache_addr, 32'h0);
    pred_jump = 1'b1;
    tick(); tick();
    rst = 1'b1; pred_jump = 1'b0;
    tick();
    chk1("arst_req_after", icache_req, 1'b1);
    chkw("arst_addr_after", icache_addr, 32'h0);
    chk1("arst_no_push", out_valid, 1'b0);
    chk1("arst_no_pred_req", pred_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetcher.md
INSTR_FETCHER -- requirements
Module: instr_fetcher

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and target width.
REQ-002 SHALL have parameter PRED_IDX_W, default 8, predictor index width, taken from pc[PRED_IDX_W+1:2].
REQ-003 SHALL have parameter IQ_DEPTH, default 16, instruction-queue entries, power of two.
REQ-004 SHALL have ports clk in 1, the single clock; rst in 1, asynchronous active-low reset; rdy in 1, global enable, low freezes all state.
REQ-005 SHALL have icache_req out 1, fetch request, level-held until icache_valid.
REQ-006 SHALL have icache_addr out ADDR_W, fetch address; icache_valid in 1, response strobe; icache_instr in 32, fetched word.
REQ-007 SHALL have pred_req out 1, prediction request; pred_index out PRED_IDX_W, branch PC index; pred_jump in 1, prediction, valid one cycle after pred_req.
REQ-008 SHALL have out_valid out 1, queue head valid; out_instr out 32; out_pc out ADDR_W; out_pred_jump out 1, predicted-taken flag; dec_ready in 1, decoder pop.
REQ-009 SHALL have rob_flush in 1, mispredict flush, also wired to icache; rob_target_pc in ADDR_W, restart PC.

Function
REQ-010 SHALL implement FSM states FETCH, PRED with FETCH as the reset state.
REQ-011 SHALL, in FETCH, assert icache_req with icache_addr=pc only while queue count < IQ_DEPTH.
REQ-012 SHALL, on icache_valid in FETCH with a non-B-type instruction, push {instr, pc, pred=0/1 per REQ-014} the same cycle, update pc, and remain in FETCH.
REQ-013 SHALL, on icache_valid with opcode 1100011 (B-type), latch instr and go to PRED.
REQ-014 SHALL use JAL (1101111) next pc = pc + sext(J-imm) with pred flag 1; JALR and all others next pc = pc+4 with pred flag 0.
REQ-015 SHALL, in PRED, hold pred_req=1 with pred_index=pc[PRED_IDX_W+1:2] for one cycle; the next cycle sample pred_jump, push with pred flag=pred_jump, set pc = pred_jump ? pc+sext(B-imm) : pc+4, and return to FETCH.
REQ-016 SHALL compute B-imm = {i[31],i[7],i[30:25],i[11:8],0} and J-imm = {i[31],i[19:12],i[20],i[30:21],0}, sign-extended to ADDR_W, with addition modulo 2^ADDR_W.
REQ-017 SHALL present the queue head on out_* with out_valid = (count != 0); pop when out_valid && dec_ready.
REQ-018 SHALL, on simultaneous push and pop, keep count unchanged and wrap both pointers modulo IQ_DEPTH.
REQ-019 SHALL never push when full; a pop while full frees the slot for the next cycle's request.
REQ-020 SHALL, on rob_flush, take priority over all events: clear queue (count=0, pointers=0), pc=rob_target_pc, state=FETCH, and drop any icache_valid, pred_jump or push in that cycle.
REQ-021 SHALL, when rdy=0, hold all registers and outputs unchanged except that rob_flush is also ignored.

Reset
REQ-022 SHALL, on rst low, asynchronously set pc=0, state=FETCH, count and pointers=0, icache_req=0, pred_req=0, out_valid=0.
REQ-023 SHALL, after rst rises, issue the first icache_req with addr 0 on the first rdy-high clock edge.
REQ-024 SHALL, on reset mid-fetch or mid-PRED, abandon the in-flight request with no push.

Structure
REQ-025 SHALL take ADDR width, opcodes (B, JAL, JALR), TRUE/FALSE and IQ_DEPTH default from the shared define file.
REQ-026 SHALL contain one sub-module, instr_queue, a synchronous FIFO of {instr, pc, pred} with push/pop/flush/count.

Verification
REQ-027 SHALL test: reset, icache returns 0x00000013 at pc 0 -> push pc 0 pred 0, next icache_addr 0x4.
REQ-028 SHALL test: instr 0x0080006F (JAL +8) at pc 0x10 -> push pred 1, next icache_addr 0x18, no pred_req.
REQ-029 SHALL test: B-type 0xFE000EE3 (beq x0,x0,-4) at pc 0x20 with pred_jump=1 -> pred_req one cycle, index 0x08, next addr 0x1C; with pred_jump=0 -> next addr 0x24.
REQ-030 SHALL test: dec_ready=0 with 16 pushes -> icache_req low at count 16; one pop -> request resumes, pointers wrap.
REQ-031 SHALL test: rob_flush with target 0x100 in the same cycle as icache_valid in PRED -> queue empty, no push, next icache_addr 0x100.
REQ-032 SHALL test: rdy=0 for 3 cycles mid-PRED -> state, pc and queue unchanged, then resumes exactly.
